// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one valid/ready command, runs the
// SETUP/ACCESS handshake, and returns a response with a timeout error if pready never arrives.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk_i,
    input  logic              prst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               cmd_fire;
    logic               wait_expired;

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign cmd_fire     = cmd_valid_i & cmd_ready_o;
    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge pclk_i or negedge prst_n) begin
        if (!prst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // pready wins over the timeout when both land in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_fire) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (pready_i || wait_expired) state_d = S_RESP;
            S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a hold default up front so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        // Bus strobes are decoded from the next state so they register in step with it.
        psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d   = (state_d == S_ACCESS);
        rsp_valid_d = (state_d == S_RESP);

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    pwrite_d = cmd_write_i;
                    paddr_d  = cmd_addr_i;
                    pwdata_d = cmd_wdata_i;
                end
            end
            S_SETUP: wait_cnt_d = '0;
            S_ACCESS: begin
                if (pready_i) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                    rsp_err_d   = 1'b0;
                end else if (wait_expired) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB master that bridges a simple valid/ready command/response interface onto the APB bus.
- It feeds the team's APB memory slave: it drives psel/penable/pwrite/paddr/pwdata and consumes pready/prdata.
- It sequences IDLE→SETUP→ACCESS, tolerates slave wait states, and aborts with an error response if pready never arrives within a bounded number of cycles.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB read/write data width.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort. Must be ≥2. Wait-counter width is clog2(TIMEOUT+1).

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- prst_n  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  master can accept a command.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_W  transfer address.
- cmd_wdata_i  in  DATA_W  write data; ignored for reads.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and on error.
- rsp_err_o  out  1  1 = transfer timed out.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  DATA_W  APB write data.
- prdata_i  in  DATA_W  APB read data.
- pready_i  in  1  APB ready.

Behaviour:
- Reset (prst_n low, asynchronous, effective immediately):
  - state=IDLE; psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter=0.
  - cmd_ready_o=1 (IDLE).
  - Reset mid-transfer drops psel/penable at once; the in-flight command and any pending response are discarded.
- All APB and response outputs are registered. cmd_ready_o is a decode of state==IDLE.
- States:
  - IDLE: cmd_ready_o=1. On cmd_valid_i & cmd_ready_o, capture write/addr/wdata into pwrite_o/paddr_o/pwdata_o → SETUP.
  - SETUP: psel_o=1, penable_o=0 for exactly one cycle → ACCESS. Clear wait counter.
  - ACCESS: psel_o=1, penable_o=1.
    - If pready_i=1: for reads, rsp_rdata_o ← prdata_i; for writes, rsp_rdata_o ← 0. Set rsp_err_o=0 → RESP.
    - Else if wait counter == TIMEOUT-1: rsp_rdata_o ← 0, rsp_err_o ← 1 → RESP (abort).
    - Else: increment wait counter and stay.
  - RESP: psel_o=0, penable_o=0, rsp_valid_o=1, held with rsp_rdata_o/rsp_err_o stable until rsp_ready_i=1 → IDLE.
- paddr_o, pwrite_o and pwdata_o stay stable from SETUP through the end of ACCESS. They hold their last value while idle; no bus activity occurs because psel_o=0.
- Latency: command accepted at edge T.
  - SETUP visible in cycle T+1; ACCESS starts in cycle T+2.
  - Zero-wait slave: rsp_valid_o=1 from T+3.
  - Each slave wait cycle adds 1.
  - Timeout: rsp_valid_o rises TIMEOUT cycles after ACCESS entry.
- Only one outstanding transfer. cmd_ready_o=0 in SETUP, ACCESS and RESP. A command presented during these states waits; no buffering.
- A pready_i=1 in the same cycle the counter reaches TIMEOUT-1 counts as success (pready has priority).
- pready_i and prdata_i are ignored outside ACCESS.
- After the RESP handshake, the earliest next acceptance is the following cycle (IDLE). Maximum throughput is one transfer per 4 cycles with a zero-wait slave.
- An abort leaves the slave unattended. Firmware treats rsp_err_o as fatal for that address.

Test Plan:
- Write-then-read, zero wait: write addr 0x10 data 0xDEADBEEF, then read 0x10.
  - Write response: rsp_err_o=0, rsp_rdata_o=0.
  - Read response: rsp_rdata_o=0xDEADBEEF.
  - Each response rsp_valid_o appears 3 cycles after acceptance; psel/penable follow the 0/0→1/0→1/1→0/0 sequence.
- Wait states: slave holds pready low 5 ACCESS cycles, read addr 0x22 returns 0x12345678 → rsp_valid_o at acceptance+8, rsp_rdata_o=0x12345678, paddr_o stable throughout.
- Timeout: pready tied 0, read addr 0x05 → abort after 16 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0, psel_o=0 from the next cycle. A later write to 0x05 with pready restored completes with rsp_err_o=0.
- Boundary: pready rises exactly on the 16th ACCESS cycle → rsp_err_o=0 and data captured.
- Backpressure: hold rsp_ready_i=0 for 10 cycles with cmd_valid_i=1 → rsp_valid_o and rsp_rdata_o held constant, cmd_ready_o=0. Second command is accepted the cycle after rsp_ready_i=1.
- Reset mid-ACCESS: assert prst_n=0 during a wait state → psel_o/penable_o=0 immediately with no clock edge. After release, cmd_ready_o=1, rsp_valid_o=0, and a new read of 0x10 completes normally.
